tree_space_manager: RTL
=======================

Name: tree_space_manager

Overview:
- Allocator of free node addresses for the BST storage RAM.
- Responds to the tree-manager request/free interface driven by the BST engine:
  - hands out an unused node address on each request;
  - recycles addresses returned through the free channel;
  - reports full when no address remains.
- Tracks allocation state per address to reject illegal frees.

Parameters:
- TOKEN_WIDTH, 8, width of a node address. Node space DEPTH = 2**TOKEN_WIDTH addresses.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  1  engine requests one address
- req_ready  out  1  allocator can grant an address this cycle
- req_addr  out  TOKEN_WIDTH  address granted on req_valid && req_ready; valid whenever full=0
- free_valid  in  1  engine returns an address
- free_ready  out  1  allocator accepts free this cycle
- free_addr  in  TOKEN_WIDTH  address being returned
- full  out  1  no address available
- used_count  out  TOKEN_WIDTH+1  number of currently allocated addresses
- free_err  out  1  one-cycle pulse: free of an address not currently allocated

Behaviour:
- Reset:
  - One clock, aclk; aresetn asynchronous, active-low.
  - All state clears immediately on aresetn=0.
  - Output values in reset: req_addr=0, full=0, used_count=0, free_err=0.
  - req_ready=0 and free_ready=0 while aresetn=0, both gated combinationally by aresetn.
- Address sources:
  - fresh_cnt: TOKEN_WIDTH+1 bits, reset 0. Addresses never yet allocated; exhausted when fresh_cnt == DEPTH.
  - recycle FIFO: DEPTH entries, holds freed addresses in return order.
  - alloc_map: DEPTH bits, bit set = address allocated.
- Show-ahead grant:
  - req_addr = FIFO head if FIFO non-empty, else fresh_cnt[TOKEN_WIDTH-1:0]. The recycled source has priority.
  - full = FIFO empty && fresh_cnt == DEPTH (combinational from registered state).
  - req_ready = aresetn && ~full.
- Allocation:
  - Fires on req_valid && req_ready.
  - Pop FIFO, or increment fresh_cnt.
  - Set alloc_map[req_addr]; used_count +1.
  - Zero added latency: the granted address is the req_addr presented in the same cycle. The next address appears the following cycle.
- Free:
  - free_ready = aresetn (always 1 out of reset). The FIFO cannot overflow because only allocated addresses are pushed.
  - On free_valid && free_ready with alloc_map[free_addr]=1: push free_addr into FIFO, clear the bit, used_count -1.
  - On free_valid && free_ready with alloc_map[free_addr]=0: no state change; free_err=1 on the next cycle, for one cycle.
- Simultaneous alloc and free in one cycle:
  - Both are performed.
  - used_count is unchanged.
  - FIFO push and pop happen in the same cycle: occupancy unchanged, order preserved.
  - A free of the address being granted in that same cycle is illegal, because its map bit is still 0. Result: free_err, the grant proceeds normally.
- Full boundary:
  - While full=1, a same-cycle free does not bypass to req_addr. The freed address becomes grantable next cycle and full deasserts next cycle.
- FIFO pointers: TOKEN_WIDTH+1 bits, wrap modulo DEPTH; the extra MSB distinguishes full from empty.
- Reset mid-operation: all allocations are forgotten. After release, grants restart at address 0 in fresh order.
- No other states: the block is a pure allocator datapath. There is no init phase; it is ready on the first cycle after reset release.

Test Plan:
- Reset release, 3 back-to-back req_valid cycles -> req_addr 0,1,2 granted; used_count=3; full=0.
- TOKEN_WIDTH=4: 16 consecutive grants -> addresses 0..15; after the last grant full=1, req_ready=0, used_count=16; further req_valid is ignored.
- From full: free 5, then free 9 on consecutive cycles -> full=0 from the cycle after free 5; next two grants return 5 then 9; full=1 again; used_count=16.
- Free 5 while address 5 is unallocated (double free) -> free_err pulses one cycle; FIFO unchanged; used_count unchanged; next grant is not 5.
- FIFO holds {7}, same cycle req_valid and free_valid with free_addr=3 (allocated) -> grant=7, 3 queued, used_count unchanged; next grant=3.
- Assert aresetn=0 mid-sequence with used_count=10 -> outputs return to reset values immediately; after release the first grant is 0 and used_count=1.

Source files
------------

// File: rtl/tree_space_manager_if.sv
// Request/free handshake bundle between the BST engine
// and the node-address allocator.
interface tree_space_manager_if #(
  parameter int TOKEN_WIDTH = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic [TOKEN_WIDTH-1:0] req_addr;
  logic                   free_valid;
  logic                   free_ready;
  logic [TOKEN_WIDTH-1:0] free_addr;
  logic                   full;
  logic [TOKEN_WIDTH:0]   used_count;
  logic                   free_err;

  modport master (
    output req_valid, free_valid, free_addr,
    input  req_ready, req_addr, free_ready,
    input  full, used_count, free_err
  );

  modport slave (
    input  req_valid, free_valid, free_addr,
    output req_ready, req_addr, free_ready,
    output full, used_count, free_err
  );
endinterface

// File: rtl/tree_space_manager.sv
// Node-address allocator for the BST storage RAM: fresh
// counter plus recycle FIFO, with a per-address alloc map.
module tree_space_manager #(
  parameter int TOKEN_WIDTH = 8
) (
  input logic                 aclk,
  input logic                 aresetn,
  tree_space_manager_if.slave bus
);
  localparam int AW    = TOKEN_WIDTH;
  localparam int DEPTH = 2**AW;

  typedef logic [AW:0] cnt_t;

  cnt_t             fresh_cnt_q, fresh_cnt_d;
  cnt_t             rd_ptr_q, rd_ptr_d;
  cnt_t             wr_ptr_q, wr_ptr_d;
  cnt_t             used_q, used_d;
  logic [DEPTH-1:0] alloc_map_q, alloc_map_d;
  logic             free_err_q, free_err_d;
  logic [AW-1:0]    fifo_mem [DEPTH];

  logic          fifo_empty;
  logic          fresh_done;
  logic          full;
  logic          alloc;
  logic          free_hit;
  logic          free_ok;
  logic          free_bad;
  logic [AW-1:0] grant_addr;

  assign fifo_empty = rd_ptr_q == wr_ptr_q;
  assign fresh_done = fresh_cnt_q == cnt_t'(DEPTH);
  assign full       = fifo_empty && fresh_done;

  // Recycled addresses win over never-used ones.
  assign grant_addr = fifo_empty ? fresh_cnt_q[AW-1:0]
                                 : fifo_mem[rd_ptr_q[AW-1:0]];

  assign bus.req_ready  = aresetn && !full;
  assign bus.free_ready = aresetn;
  assign bus.req_addr   = grant_addr;
  assign bus.full       = full;
  assign bus.used_count = used_q;
  assign bus.free_err   = free_err_q;

  assign alloc    = bus.req_valid && bus.req_ready;
  assign free_hit = bus.free_valid && bus.free_ready;
  assign free_ok  = free_hit && alloc_map_q[bus.free_addr];
  assign free_bad = free_hit && !alloc_map_q[bus.free_addr];

  always_comb begin
    fresh_cnt_d = fresh_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    alloc_map_d = alloc_map_q;
    free_err_d  = free_bad;
    used_d      = used_q
                + {{AW{1'b0}}, alloc}
                - {{AW{1'b0}}, free_ok};
    if (alloc) begin
      alloc_map_d[grant_addr] = 1'b1;
      if (fifo_empty) fresh_cnt_d = fresh_cnt_q + 1'b1;
      else            rd_ptr_d    = rd_ptr_q + 1'b1;
    end
    // A grant's map bit is clear, so a legal free never hits it.
    if (free_ok) begin
      alloc_map_d[bus.free_addr] = 1'b0;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fresh_cnt_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      used_q      <= '0;
      alloc_map_q <= '0;
      free_err_q  <= 1'b0;
    end else begin
      fresh_cnt_q <= fresh_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      used_q      <= used_d;
      alloc_map_q <= alloc_map_d;
      free_err_q  <= free_err_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (free_ok) fifo_mem[wr_ptr_q[AW-1:0]] <= bus.free_addr;
  end
endmodule
